axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
Shares one AXI4 read channel (AR/R) between two cache refill masters: m0 = icache fill, m1 = dcache fill. Only one burst is outstanding at a time. Masters are granted round-robin, AR fields are latched, and R beats are routed back to the granted master. Sits between the cache fill units and the SoC AXI interconnect. Flags protocol violations on the returned burst.

Parameters:
ADDR_W, 64, address width
DATA_W, 128, read data width
M0_ID, 4'b0000, ARID driven for m0 bursts
M1_ID, 4'b0001, ARID driven for m1 bursts

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_arvalid/m1_arvalid  in  1  master read request
m0_araddr/m1_araddr  in  ADDR_W  request address
m0_arlen/m1_arlen  in  8  beats-1
m0_arsize/m1_arsize  in  3  beat size
m0_arburst/m1_arburst  in  2  burst type
m0_arready/m1_arready  out  1  request accepted
m0_rvalid/m1_rvalid  out  1  routed read beat valid
m0_rready/m1_rready  in  1  master beat ready
m0_rdata/m1_rdata  out  DATA_W  routed data (shared fanout of s_rdata)
m0_rresp/m1_rresp  out  2  routed response
m0_rlast/m1_rlast  out  1  routed last
s_arvalid  out  1  downstream AR valid
s_araddr  out  ADDR_W  latched address
s_arid  out  4  M0_ID or M1_ID
s_arlen  out  8  latched length
s_arsize  out  3  latched size
s_arburst  out  2  latched burst
s_arready  in  1  downstream AR ready
s_rvalid  in  1  downstream R valid
s_rready  out  1  downstream R ready
s_rdata  in  DATA_W  read data
s_rresp  in  2  read response
s_rlast  in  1  last beat
s_rid  in  4  read ID
proto_err  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rr_last=1 so m0 wins the first tie; beat_cnt=0; proto_err=0. Outputs during and after reset: s_arvalid=0, s_rready=0, m*_arready=0, m*_rvalid=0, m*_rlast=0. Reset mid-burst abandons the burst. Remaining downstream beats are not drained.
- FSM states: IDLE, AR, R.
- IDLE arbitration:
  - If exactly one m*_arvalid is high, grant that master.
  - If both are high, grant the master != rr_last.
  - The granted m*_arready is driven combinationally high in the same cycle. Only one arready is ever high.
  - On the grant edge: latch araddr/arlen/arsize/arburst, set gnt, set s_arid from gnt, clear beat_cnt, go to AR.
- AR: s_arvalid=1 with the latched fields stable. When s_arready=1, go to R and set rr_last=gnt. Accept-to-s_arvalid latency is 1 cycle. Minimum request-to-downstream-handshake is 2 cycles.
- R routing:
  - m[gnt]_rvalid = s_rvalid.
  - s_rready = m[gnt]_rready.
  - rdata/rresp/rlast are forwarded unmodified; rresp SLVERR/DECERR passes through.
  - The non-granted master's rvalid is 0.
  - Each handshake (s_rvalid && s_rready) increments beat_cnt (8-bit, wraps at 255).
- R exit: a handshake with s_rlast=1 goes to IDLE. The next grant can occur in the cycle after rlast, so a new burst is accepted at the earliest 1 cycle after rlast.
- proto_err is set (sticky until reset) by any of:
  - a handshake beat with s_rid != s_arid;
  - s_rlast=1 on a handshake where beat_cnt != latched arlen;
  - a handshake where beat_cnt == arlen but s_rlast=0.
  The burst still terminates only on s_rlast.
- s_rvalid outside state R is ignored: s_rready=0 and no error.
- m*_arready=0 in AR and R. Requesters hold arvalid until accepted.
- Back-pressure: a master holding rready=0 stalls the downstream burst. There is no buffering.

Test Plan:
- m0 only, araddr=0x1000, arlen=15: m0_arready in cycle 0, s_arvalid in cycle 1 with s_arid=0, s_arready=1 -> 16 beats to m0. m0_rlast on beat 16, back to IDLE, proto_err=0.
- m0 and m1 both request from reset: m0 granted first. The next simultaneous request grants m1, then m0 again (strict alternation over 4 bursts).
- m1 burst with m1_rready toggling 1/0 each cycle: s_rready mirrors it, 16 beats complete in 31 cycles, data order preserved, m0_rvalid never 1.
- arlen=15 with s_rlast asserted on beat 8: proto_err=1 and state=IDLE. A second burst completes normally and proto_err stays 1.
- m0 burst, s_rid=4'b0001 on beat 3: proto_err=1. All 16 beats are still delivered to m0.
- reset asserted in R after beat 5: next cycle all outputs are at reset values and state=IDLE. A new m1 request is granted with s_arid=1.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI4 read channel between icache (m0) and dcache (m1) fills
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128,
  parameter logic [3:0] M0_ID = 4'b0000,
  parameter logic [3:0] M1_ID = 4'b0001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_arready,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_arready,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_arready,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_nxt;
  logic rr_last, gnt, gnt_req, grant, hs, in_r, beat_err;
  logic [7:0] beat_cnt, len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic [3:0] id_q;
  assign gnt_req = (m0_arvalid && m1_arvalid) ? ~rr_last : m1_arvalid;
  assign grant = (state == IDLE) && (m0_arvalid || m1_arvalid) && !reset;
  assign in_r = (state == R) && !reset;
  assign hs = in_r && s_rvalid && s_rready;
  assign beat_err = (s_rid != id_q) || (s_rlast != (beat_cnt == len_q));
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (grant ? AR : IDLE) :
                (state == AR)   ? (s_arready ? R : AR) :
                                  ((hs && s_rlast) ? IDLE : R);
  always_ff @(posedge clock)
    if (reset) begin
      rr_last   <= 1'b1;
      gnt       <= 1'b0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      id_q      <= M0_ID;
    end else begin
      if (grant) begin
        gnt      <= gnt_req;
        addr_q   <= gnt_req ? m1_araddr : m0_araddr;
        len_q    <= gnt_req ? m1_arlen : m0_arlen;
        size_q   <= gnt_req ? m1_arsize : m0_arsize;
        burst_q  <= gnt_req ? m1_arburst : m0_arburst;
        id_q     <= gnt_req ? M1_ID : M0_ID;
        beat_cnt <= '0;
      end
      if (state == AR && s_arready) rr_last <= gnt;
      if (hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (beat_err) proto_err <= 1'b1;
      end
    end
  always_comb begin
    m0_arready = grant && !gnt_req;
    m1_arready = grant && gnt_req;
    s_arvalid  = (state == AR) && !reset;
    s_araddr   = addr_q;
    s_arid     = id_q;
    s_arlen    = len_q;
    s_arsize   = size_q;
    s_arburst  = burst_q;
    s_rready   = in_r && (gnt ? m1_rready : m0_rready);
    m0_rvalid  = in_r && !gnt && s_rvalid;
    m1_rvalid  = in_r && gnt && s_rvalid;
    m0_rlast   = in_r && !gnt && s_rlast;
    m1_rlast   = in_r && gnt && s_rlast;
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rresp   = s_rresp;
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
  logic clock = 0, reset = 0;
  logic m0_arvalid = 0, m1_arvalid = 0, m0_rready = 1, m1_rready = 1;
  logic [63:0] m0_araddr = 0, m1_araddr = 0;
  logic [7:0] m0_arlen = 0, m1_arlen = 0;
  logic [2:0] m0_arsize = 3'd4, m1_arsize = 3'd4;
  logic [1:0] m0_arburst = 2'd1, m1_arburst = 2'd1;
  logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [127:0] m0_rdata, m1_rdata;
  logic [1:0] m0_rresp, m1_rresp;
  logic s_arvalid, s_rready, proto_err;
  logic [63:0] s_araddr;
  logic [3:0] s_arid;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst;
  logic s_arready = 0, s_rvalid = 0, s_rlast = 0;
  logic [127:0] s_rdata = 0;
  logic [1:0] s_rresp = 0;
  logic [3:0] s_rid = 0;
  int pass_cnt = 0, total_cnt = 0;
  logic exp_err = 0;
  logic [75:0] arq[$];
  logic [131:0] rq[$];

  axi_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  function automatic logic [127:0] bdata(input logic [63:0] addr, input int i);
    logic [7:0] b = 8'(i);
    return {addr, 56'h0, b};
  endfunction

  function automatic logic [1:0] bresp(input int i);
    return (i == 1) ? 2'b10 : (i == 2) ? 2'b11 : 2'b00;
  endfunction

  always @(negedge clock) if (!reset) begin
    if (s_arvalid && s_arready) begin
      if (arq.size() == 0) chk("ar_unexpected", 1, 0);
      else chk("ar_fields", {s_araddr, s_arid, s_arlen}, arq.pop_front());
      chk("ar_size_burst", {s_arsize, s_arburst}, {3'd4, 2'd1});
    end
    if (m0_rvalid && m0_rready) begin
      if (rq.size() == 0) chk("m0_beat_unexpected", 1, 0);
      else chk("m0_beat", {1'b0, m0_rdata, m0_rresp, m0_rlast}, rq.pop_front());
    end
    if (m1_rvalid && m1_rready) begin
      if (rq.size() == 0) chk("m1_beat_unexpected", 1, 0);
      else chk("m1_beat", {1'b1, m1_rdata, m1_rresp, m1_rlast}, rq.pop_front());
    end
  end

  task automatic chk_idle_outs(input string name);
    chk(name, {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast}, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1;
    m0_arvalid = 1;
    s_rvalid = 1;
    @(negedge clock);
    chk_idle_outs("in_reset_outs");
    @(posedge clock); #1;
    m0_arvalid = 0;
    s_rvalid = 0;
    @(posedge clock); #1;
    reset = 0;
    rq.delete();
    arq.delete();
    exp_err = 0;
    @(negedge clock);
    chk_idle_outs("post_reset_outs");
    chk("post_reset_err", proto_err, 0);
    @(posedge clock); #1;
  endtask

  task automatic req(input bit m, input logic [63:0] addr, input logic [7:0] len);
    if (m) begin m1_arvalid = 1; m1_araddr = addr; m1_arlen = len; end
    else begin m0_arvalid = 1; m0_araddr = addr; m0_arlen = len; end
    @(negedge clock);
    chk("arready_cycle0", {m1_arready, m0_arready}, m ? 2'b10 : 2'b01);
    @(posedge clock); #1;
    if (m) m1_arvalid = 0; else m0_arvalid = 0;
    @(negedge clock);
    chk("s_arvalid_cycle1", s_arvalid, 1);
    @(posedge clock); #1;
  endtask

  task automatic drive_beat(input bit m, input logic [63:0] addr, input int i, input int last_at, input int bad_beat);
    logic [3:0] id = m ? 4'd1 : 4'd0;
    s_rvalid = 1;
    s_rdata = bdata(addr, i);
    s_rresp = bresp(i);
    s_rlast = (i == last_at);
    s_rid = (i == bad_beat) ? (id ^ 4'd1) : id;
    rq.push_back({m, bdata(addr, i), bresp(i), i == last_at});
  endtask

  task automatic serve(input bit m, input logic [63:0] addr, input logic [7:0] len, input int last_at,
                       input int bad_beat, input bit tog, input int abort_at);
    int i = 0, cyc = 0, w = 0;
    bit hs;
    arq.push_back({addr, m ? 4'd1 : 4'd0, len});
    while (!s_arvalid && w < 20) begin @(posedge clock); #1; w++; end
    if (w == 20) begin chk("ar_timeout", 0, 1); return; end
    s_arready = 1;
    @(posedge clock); #1;
    s_arready = 0;
    if (m) m1_rready = 1; else m0_rready = 1;
    drive_beat(m, addr, 0, last_at, bad_beat);
    forever begin
      @(negedge clock);
      cyc++;
      hs = s_rready;
      chk("s_rready_mirror", s_rready, m ? m1_rready : m0_rready);
      chk("other_rvalid", m ? m0_rvalid : m1_rvalid, 0);
      @(posedge clock); #1;
      if (hs) begin
        if (i == last_at) break;
        i++;
        if (i == abort_at) begin
          reset = 1;
          rq.delete();
          @(negedge clock);
          chk_idle_outs("abort_reset_outs");
          @(posedge clock); #1;
          reset = 0;
          exp_err = 0;
          @(negedge clock);
          chk_idle_outs("abort_post_outs");
          chk("abort_err", proto_err, 0);
          @(posedge clock); #1;
          s_rvalid = 0;
          s_rlast = 0;
          return;
        end
        drive_beat(m, addr, i, last_at, bad_beat);
      end
      if (tog) begin if (m) m1_rready = ~m1_rready; else m0_rready = ~m0_rready; end
      if (cyc > 100) begin chk("beat_timeout", 0, 1); break; end
    end
    s_rvalid = 0;
    s_rlast = 0;
    m0_rready = 1;
    m1_rready = 1;
    chk("burst_cycles", cyc, tog ? 2 * (last_at + 1) - 1 : last_at + 1);
    chk("beats_drained", rq.size(), 0);
    exp_err = exp_err | (bad_beat >= 0 && bad_beat <= last_at) | (last_at != int'(len));
    chk("proto_err", proto_err, exp_err);
  endtask

  initial begin
    do_reset();
    req(0, 64'h1000, 8'd15);
    serve(0, 64'h1000, 8'd15, 15, -1, 0, -1);
    do_reset();
    m0_araddr = 64'h2000; m0_arlen = 8'd1;
    m1_araddr = 64'h3000; m1_arlen = 8'd2;
    m0_arvalid = 1; m1_arvalid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("rr_grant", {m1_arready, m0_arready}, (k % 2) ? 2'b10 : 2'b01);
      @(posedge clock); #1;
      if (k % 2) m1_arvalid = 0; else m0_arvalid = 0;
      if (k % 2) serve(1, 64'h3000, 8'd2, 2, -1, 0, -1);
      else serve(0, 64'h2000, 8'd1, 1, -1, 0, -1);
      if (k < 3) begin if (k % 2) m1_arvalid = 1; else m0_arvalid = 1; end
    end
    req(1, 64'h4000, 8'd15);
    serve(1, 64'h4000, 8'd15, 15, -1, 1, -1);
    req(0, 64'h5000, 8'd15);
    serve(0, 64'h5000, 8'd15, 7, -1, 0, -1);
    req(1, 64'h6000, 8'd3);
    serve(1, 64'h6000, 8'd3, 3, -1, 0, -1);
    do_reset();
    req(0, 64'h7000, 8'd15);
    serve(0, 64'h7000, 8'd15, 15, 2, 0, -1);
    req(0, 64'h8000, 8'd15);
    serve(0, 64'h8000, 8'd15, 15, -1, 0, 5);
    req(1, 64'h9000, 8'd3);
    serve(1, 64'h9000, 8'd3, 3, -1, 0, -1);
    chk("ar_drained", arq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
